// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Buffered byte source for an 8N2 UART transmitter. Bytes arrive on a
//   valid/ready stream into a FIFO of 2**DEPTH_LOG2 entries. Each byte is then
//   launched to the UART with a one-cycle uart_transmit pulse. The next byte is
//   not launched until the UART has raised and then dropped its busy flag.
//
//   Optional feature macro: UART_TX_XONXOFF_EN
//     defined   : XOFF_CHAR / XON_CHAR seen on the UART receiver pause/resume
//                 launching (a frame already launched still completes).
//     undefined : paused is tied to 0; rx inputs and XON/XOFF chars are unused.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_data/s_valid       byte stream in
//   s_ready              FIFO not full
//   uart_transmit        one-cycle launch pulse
//   uart_tx_byte         byte being sent; holds until the next load
//   uart_is_transmitting UART busy flag
//   uart_received        UART rx strobe (XON/XOFF only)
//   uart_rx_byte         UART rx byte (XON/XOFF only)
//   level                bytes held in FIFO (byte in flight excluded)
//   empty, full          FIFO status
//   paused               XOFF in force

module uart_tx_feeder #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] XOFF_CHAR  = 8'h13,
    parameter logic [7:0] XON_CHAR   = 8'h11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting,
    input  logic                  uart_received,
    input  logic [7:0]            uart_rx_byte,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  paused
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  launch_ok;

    assign full      = (level == LEVEL_FULL);
    assign empty     = (level == '0);
    assign s_ready   = !full;
    assign push      = s_valid && s_ready;
    assign launch_ok = !empty && !paused && !uart_is_transmitting;
    // The head byte leaves the FIFO on the same edge the FSM leaves IDLE.
    assign pop       = (state == IDLE) && launch_ok;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally at DEPTH_LOG2 bits. A push can never coincide
    // with full (s_ready=0), so level cannot exceed LEVEL_FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Launch FSM. WAIT_BUSY guarantees the UART has actually picked up the
    // frame before WAIT_DONE looks for the falling edge of busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        uart_tx_byte  <= mem[rd_ptr];
                        uart_transmit <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    uart_transmit <= 1'b0;
                    state         <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_is_transmitting) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_transmit <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_XONXOFF_EN
    // Flow control only gates IDLE->LAUNCH through launch_ok, so a frame
    // already launched always runs to completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            paused <= 1'b0;
        end else if (uart_received) begin
            if (uart_rx_byte == XOFF_CHAR) begin
                paused <= 1'b1;
            end else if (uart_rx_byte == XON_CHAR) begin
                paused <= 1'b0;
            end
        end
    end
`else
    assign paused = 1'b0;

    logic unused_xonxoff;
    assign unused_xonxoff = &{1'b0, uart_received, uart_rx_byte, XOFF_CHAR, XON_CHAR};
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: table-driven single-byte launches,
// hand-written multi-cycle sequences and a randomized stream, all checked
// against a queue-based reference of what must be sent and how much is held.

module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       uart_received;
    logic [7:0] uart_rx_byte;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       paused;

    uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_data               (s_data),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .level                (level),
        .empty                (empty),
        .full                 (full),
        .paused               (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // UART model + reference scoreboard
    logic       hold_busy  = 1'b0;
    logic       model_busy = 1'b0;
    logic       mon_en     = 1'b0;
    logic       rand_frames = 1'b0;
    int         frame_len  = 4;
    int         uart_cnt   = 0;
    int         n_push     = 0;
    int         n_launch   = 0;
    logic       pend       = 1'b0;
    logic [7:0] pend_byte  = 8'h00;
    logic       prev_tx    = 1'b0;
    logic [7:0] mdl_q[$];

    assign uart_is_transmitting = model_busy | hold_busy;

    always @(negedge clk) begin
        if (rst) begin
            uart_cnt = 0;
            mdl_q.delete();
            pend     = 1'b0;
            n_push   = n_launch;
            prev_tx  = 1'b0;
        end else begin
            // a push seen last cycle took effect on the edge in between
            if (pend) begin
                mdl_q.push_back(pend_byte);
                pend = 1'b0;
            end
            if (uart_transmit === 1'b1) begin
                if (mon_en) begin
                    chk("launch_while_busy", 32'(uart_is_transmitting), 32'd0);
                    chk("pulse_width", 32'(prev_tx), 32'd0);
                    if (mdl_q.size() == 0)
                        chk("launch_from_empty", 32'(uart_transmit), 32'd0);
                    else
                        chk("tx_byte_order", 32'(uart_tx_byte), 32'(mdl_q.pop_front()));
                end
                n_launch++;
                uart_cnt = rand_frames ? int'($urandom_range(2, 6)) : frame_len;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
            end
            if (mon_en) begin
                chk("level", 32'(level), 32'(mdl_q.size()));
                chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
                chk("full", 32'(full), 32'(mdl_q.size() == DEPTH));
                chk("s_ready", 32'(s_ready), 32'(mdl_q.size() < DEPTH));
            end
            if (s_valid && s_ready) begin
                pend      = 1'b1;
                pend_byte = s_data;
                n_push++;
            end
            prev_tx = uart_transmit;
        end
        model_busy = (uart_cnt != 0);
    end

    // Stimulus helpers; every drive point is 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int i;
        s_valid = 1'b1;
        s_data  = b;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        chk("push_timeout", 32'(i < 300), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_launches(input int target, input int budget);
        for (int i = 0; i < budget && n_launch < target; i++) @(negedge clk);
        chk("launch_count", 32'(n_launch), 32'(target));
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 500 && quiet < 3; i++) begin
            @(negedge clk);
            if (!uart_is_transmitting) quiet++;
            else quiet = 0;
        end
        chk("idle_timeout", 32'(quiet), 32'd3);
        step();
    endtask

    task automatic rx_inject(input logic [7:0] b);
        uart_received = 1'b1;
        uart_rx_byte  = b;
        step();
        uart_received = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        int         frame;
        int         exp_lat;
        logic [7:0] exp_byte;
        logic [4:0] exp_level;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        vecs[0] = '{8'hA5, 2, 2, 8'hA5, 5'd0};
        vecs[1] = '{8'h00, 3, 2, 8'h00, 5'd0};
        vecs[2] = '{8'hFF, 5, 2, 8'hFF, 5'd0};
        vecs[3] = '{8'h5A, 9, 2, 8'h5A, 5'd0};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        uart_received = 1'b0; uart_rx_byte = 8'h00;

        // reset state
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_transmit", 32'(uart_transmit), 32'd0);
        chk("rst_tx_byte", 32'(uart_tx_byte), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        mon_en = 1'b1;
        step();

        // single-byte launches: latency, byte, level
        for (int i = 0; i < 4; i++) begin
            frame_len = vecs[i].frame;
            s_valid = 1'b1;
            s_data  = vecs[i].data;
            @(negedge clk);
            chk("vec_ready", 32'(s_ready), 32'd1);
            step();
            s_valid = 1'b0;
            for (lat = 1; lat <= 8; lat++) begin
                @(negedge clk);
                if (uart_transmit === 1'b1) break;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_byte", i), 32'(uart_tx_byte), 32'(vecs[i].exp_byte));
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_off", i), 32'(uart_transmit), 32'd0);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            wait_idle();
            chk($sformatf("vec%0d_hold", i), 32'(uart_tx_byte), 32'(vecs[i].exp_byte));
        end

        // fill with UART held busy, then stream 40 more through a full FIFO
        n0 = n_launch;
        frame_len = 3;
        hold_busy = 1'b1;
        for (int b = 0; b < 16; b++) push_byte(8'(b));
        @(negedge clk);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_s_ready", 32'(s_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_no_launch", 32'(n_launch), 32'(n0));
        step();
        hold_busy = 1'b0;
        for (int b = 16; b < 56; b++) push_byte(8'(b));
        wait_launches(n0 + 56, 3000);
        wait_idle();
        chk("stream_empty", 32'(empty), 32'd1);

        // randomized traffic with random frame lengths
        rand_frames = 1'b1;
        for (int c = 0; c < 400; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            step();
        end
        s_valid = 1'b0;
        wait_launches(n_push, 4000);
        wait_idle();
        rand_frames = 1'b0;

        // flow control
        n0 = n_launch;
        frame_len = 20;
        hold_busy = 1'b1;
        push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
        hold_busy = 1'b0;
        wait_launches(n0 + 1, 50);
        step();
        rx_inject(8'h13);
        @(negedge clk);
`ifdef UART_TX_XONXOFF_EN
        chk("xoff_paused", 32'(paused), 32'd1);
        step();
        repeat (1000) step();
        chk("xoff_no_launch", 32'(n_launch), 32'(n0 + 1));
        chk("xoff_level", 32'(level), 32'd2);
        rx_inject(8'h41);
        @(negedge clk);
        chk("other_char_ignored", 32'(paused), 32'd1);
        step();
        rx_inject(8'h11);
        @(negedge clk);
        chk("xon_resumed", 32'(paused), 32'd0);
        step();
`else
        chk("no_macro_paused", 32'(paused), 32'd0);
        step();
`endif
        wait_launches(n0 + 3, 300);
        wait_idle();

        // reset in the middle of a frame with 5 bytes still queued
        n0 = n_launch;
        frame_len = 40;
        hold_busy = 1'b1;
        for (int b = 0; b < 6; b++) push_byte(8'hC0 + 8'(b));
        hold_busy = 1'b0;
        wait_launches(n0 + 1, 50);
        repeat (3) @(negedge clk);
        chk("mid_level", 32'(level), 32'd5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_transmit", 32'(uart_transmit), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_tx_byte", 32'(uart_tx_byte), 32'd0);
        n0 = n_launch;
        repeat (100) step();
        chk("no_stale_launch", 32'(n_launch), 32'(n0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
